// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle CPU sequencer covering fetch, decode, execute,
// memory and write-back, with ack timeouts, illegal-instruction traps and
// a retired-instruction counter.
module cpu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_legal,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_rf_we,
  input  logic        i_lsu_we,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_taken,
  output logic        o_if_req,
  input  logic        i_if_ack,
  output logic        o_ir_we,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_rf_we,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_retire,
  output logic [31:0] o_instret,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic [2:0]  o_state
);

  localparam int unsigned WaitW   = 8;
  localparam int unsigned CountW  = 32;
  localparam logic [WaitW-1:0] TimeoutW = WaitW'(TIMEOUT);

  localparam logic [1:0] WbSelLsu     = 2'b01;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseFetchTo = 2'b10;
  localparam logic [1:0] CauseMemTo   = 2'b11;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [1:0]          cause_q, cause_d;
  logic [CountW-1:0]   instret_q, instret_d;

  // Next-state, wait counter, trap cause and retire counter update.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        if (i_if_ack) begin
          state_d = S_DECODE;
        end else if (wait_q == TimeoutW) begin
          state_d = S_TRAP;
          cause_d = CauseFetchTo;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      S_DECODE: begin
        if (!i_legal) begin
          state_d = S_TRAP;
          cause_d = CauseIllegal;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((i_wb_sel == WbSelLsu) || i_lsu_we) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (i_dmem_ack) begin
          state_d = S_WB;
        end else if (wait_q == TimeoutW) begin
          state_d = S_TRAP;
          cause_d = CauseMemTo;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        wait_d    = '0;
        instret_d = instret_q + CountW'(1);
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State and counters, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_BOOT;
      wait_q    <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Per-state strobes; reset forces BOOT so every strobe drops immediately.
  always_comb begin
    o_if_req   = 1'b0;
    o_ir_we    = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 1'b0;
    o_retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_if_req = 1'b1;
        o_ir_we  = i_if_ack;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_lsu_we;
      end
      S_WB: begin
        o_rf_we  = i_rf_we;
        o_pc_we  = 1'b1;
        o_pc_sel = i_jump | (i_branch & i_taken);
        o_retire = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_trap       = (state_q == S_TRAP);
  assign o_trap_cause = cause_q;
  assign o_instret    = instret_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: a per-instruction timeline generator
// predicts every cycle's outputs, a single player drives and compares.
module tb_cpu_ctrl;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst_n;
  logic        legal, branch, jump, rf_we_in, lsu_we, taken;
  logic [1:0]  wb_sel;
  logic        if_ack, dmem_ack;
  logic        if_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, trap;
  logic [31:0] instret;
  logic [1:0]  cause;
  logic [2:0]  state;

  cpu_ctrl #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_legal(legal), .i_branch(branch), .i_jump(jump),
    .i_rf_we(rf_we_in), .i_lsu_we(lsu_we), .i_wb_sel(wb_sel), .i_taken(taken),
    .o_if_req(if_req), .i_if_ack(if_ack), .o_ir_we(ir_we),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ack(dmem_ack),
    .o_rf_we(rf_we), .o_pc_we(pc_we), .o_pc_sel(pc_sel),
    .o_retire(retire), .o_instret(instret),
    .o_trap(trap), .o_trap_cause(cause), .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       legal;
    logic       branch;
    logic       jump;
    logic       rf_we;
    logic       lsu_we;
    logic [1:0] wb_sel;
    logic       taken;
  } dec_t;

  typedef struct packed {
    dec_t        d;
    logic        if_ack;
    logic        dmem_ack;
    logic [2:0]  st;
    logic        if_req;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        pc_we;
    logic        pc_sel;
    logic        retire;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] instret;
  } step_t;

  step_t       sq[$];
  logic [31:0] m_instret;
  logic [1:0]  m_cause;
  int          checks;
  int          failures;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic dec_t rnd_dec(logic lg);
    dec_t d;
    d = dec_t'(8'($urandom_range(0, 255)));
    d.legal = lg;
    return d;
  endfunction

  // A cycle with all outputs idle; unmatched acks are random noise.
  function automatic step_t mk(dec_t d, logic [2:0] st);
    step_t s;
    s          = '0;
    s.d        = d;
    s.st       = st;
    s.cause    = m_cause;
    s.instret  = m_instret;
    s.if_ack   = 1'($urandom_range(0, 1));
    s.dmem_ack = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic add_trap(logic [1:0] c, int len);
    step_t s;
    m_cause = c;
    for (int i = 0; i < len; i++) begin
      s      = mk(rnd_dec(1'($urandom_range(0, 1))), 3'd6);
      s.trap = 1'b1;
      sq.push_back(s);
    end
  endtask

  // Expand one instruction into its cycle timeline. fw/mw is the ack wait;
  // a wait beyond the timeout means the ack never comes.
  task automatic plan(dec_t d, int fw, int mw, int trap_len);
    step_t s;
    bit    is_mem;
    is_mem = (d.wb_sel == 2'b01) || d.lsu_we;
    for (int k = 0; k <= fw && k <= int'(TO); k++) begin
      s        = mk(d, 3'd1);
      s.if_req = 1'b1;
      s.if_ack = (k == fw);
      s.ir_we  = (k == fw);
      sq.push_back(s);
    end
    if (fw > int'(TO)) begin
      add_trap(2'b10, trap_len);
      return;
    end
    sq.push_back(mk(d, 3'd2));
    if (!d.legal) begin
      add_trap(2'b01, trap_len);
      return;
    end
    sq.push_back(mk(d, 3'd3));
    if (is_mem) begin
      for (int k = 0; k <= mw && k <= int'(TO); k++) begin
        s          = mk(d, 3'd4);
        s.dmem_req = 1'b1;
        s.dmem_we  = d.lsu_we;
        s.dmem_ack = (k == mw);
        sq.push_back(s);
      end
      if (mw > int'(TO)) begin
        add_trap(2'b11, trap_len);
        return;
      end
    end
    s        = mk(d, 3'd5);
    s.rf_we  = d.rf_we;
    s.pc_we  = 1'b1;
    s.pc_sel = d.jump | (d.branch & d.taken);
    s.retire = 1'b1;
    sq.push_back(s);
    m_instret = m_instret + 32'd1;
  endtask

  function automatic int first_idx(bit want_retire, logic [2:0] st);
    for (int i = 0; i < sq.size(); i++)
      if (want_retire ? sq[i].retire : (sq[i].st == st)) return i;
    return -1;
  endfunction

  // Drive each planned cycle just after the edge, compare at the falling edge.
  task automatic play_n(int n);
    step_t s;
    for (int i = 0; i < n && sq.size() > 0; i++) begin
      s = sq.pop_front();
      legal = s.d.legal; branch = s.d.branch; jump = s.d.jump;
      rf_we_in = s.d.rf_we; lsu_we = s.d.lsu_we; wb_sel = s.d.wb_sel;
      taken = s.d.taken; if_ack = s.if_ack; dmem_ack = s.dmem_ack;
      @(negedge clk);
      chk("state",    32'(state),    32'(s.st));
      chk("if_req",   32'(if_req),   32'(s.if_req));
      chk("ir_we",    32'(ir_we),    32'(s.ir_we));
      chk("dmem_req", 32'(dmem_req), 32'(s.dmem_req));
      chk("dmem_we",  32'(dmem_we),  32'(s.dmem_we));
      chk("rf_we",    32'(rf_we),    32'(s.rf_we));
      chk("pc_we",    32'(pc_we),    32'(s.pc_we));
      chk("pc_sel",   32'(pc_sel),   32'(s.pc_sel));
      chk("retire",   32'(retire),   32'(s.retire));
      chk("trap",     32'(trap),     32'(s.trap));
      chk("cause",    32'(cause),    32'(s.cause));
      chk("instret",  instret,       s.instret);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic play_all();
    play_n(sq.size());
  endtask

  // Assert reset mid-cycle, check everything is idle, release, play BOOT.
  task automatic do_reset();
    rst_n = 1'b0; if_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    chk("rst_state",   32'(state),    32'd0);
    chk("rst_if_req",  32'(if_req),   32'd0);
    chk("rst_ir_we",   32'(ir_we),    32'd0);
    chk("rst_dmem",    32'(dmem_req), 32'd0);
    chk("rst_retire",  32'(retire),   32'd0);
    chk("rst_pc_we",   32'(pc_we),    32'd0);
    chk("rst_trap",    32'(trap),     32'd0);
    chk("rst_cause",   32'(cause),    32'd0);
    chk("rst_instret", instret,       32'd0);
    sq.delete();
    m_instret = '0;
    m_cause   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sq.push_back(mk(rnd_dec(1'b1), 3'd0));
    play_n(1);
  endtask

  dec_t d_add, d_load, d_br, d_jal, d_st;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; legal = 0; branch = 0; jump = 0; rf_we_in = 0;
    lsu_we = 0; wb_sel = 0; taken = 0; if_ack = 0; dmem_ack = 0;
    m_instret = '0; m_cause = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // ADD: retire in the 4th cycle counted from FETCH, instret becomes 1.
    d_add = '{legal:1, branch:0, jump:0, rf_we:1, lsu_we:0, wb_sel:2'b00, taken:0};
    plan(d_add, 0, 0, 0);
    chk("pin_add_wb_idx", 32'(first_idx(1'b1, 3'd0)), 32'd3);
    play_all();
    chk("add_instret", instret, 32'd1);

    // Load with ack on the 4th MEM cycle: WB lands in cycle 8.
    d_load = '{legal:1, branch:0, jump:0, rf_we:1, lsu_we:0, wb_sel:2'b01, taken:0};
    plan(d_load, 0, 3, 0);
    chk("pin_load_wb_idx", 32'(first_idx(1'b1, 3'd0)), 32'd7);
    chk("pin_load_mem_idx", 32'(first_idx(1'b0, 3'd4)), 32'd3);
    play_all();

    // Branches and JAL.
    d_br = '{legal:1, branch:1, jump:0, rf_we:0, lsu_we:0, wb_sel:2'b00, taken:0};
    plan(d_br, 1, 0, 0);
    d_br.taken = 1'b1;
    plan(d_br, 0, 0, 0);
    d_jal = '{legal:1, branch:0, jump:1, rf_we:1, lsu_we:0, wb_sel:2'b11, taken:0};
    plan(d_jal, 2, 0, 0);
    d_st = '{legal:1, branch:0, jump:0, rf_we:0, lsu_we:1, wb_sel:2'b00, taken:0};
    plan(d_st, 0, 4, 0);
    play_all();
    chk("instret_after_6", instret, 32'd6);

    // Ack in the very cycle the counter reaches the timeout wins.
    plan(d_add, int'(TO), 0, 0);
    chk("pin_late_ack_decode", 32'(first_idx(1'b0, 3'd2)), 32'(TO + 1));
    play_all();

    // Random legal instructions with random ack waits up to the limit.
    for (int i = 0; i < 40; i++) begin
      plan(rnd_dec(1'b1), int'($urandom_range(0, TO)), int'($urandom_range(0, TO)), 0);
      play_all();
    end

    // Fetch timeout: 5 FETCH cycles without ack, then TRAP cause 10.
    plan(d_add, int'(TO) + 1, 0, 20);
    chk("pin_fetch_to_trap_idx", 32'(first_idx(1'b0, 3'd6)), 32'(TO + 1));
    play_all();
    chk("fetch_to_cause", 32'(cause), 32'd2);
    do_reset();

    // Memory timeout: TRAP cause 11, store never retires.
    plan(d_st, 0, int'(TO) + 1, 20);
    play_all();
    chk("mem_to_cause", 32'(cause), 32'd3);
    do_reset();

    // Illegal instruction: TRAP cause 01 held for 100 cycles.
    plan(d_add, 0, 0, 0);
    plan(rnd_dec(1'b0), 1, 0, 100);
    play_all();
    chk("illegal_trap", 32'(trap), 32'd1);
    chk("illegal_cause", 32'(cause), 32'd1);
    chk("illegal_instret", instret, 32'd1);
    do_reset();

    // Reset in the middle of a MEM wait drops the request at once.
    plan(d_add, 0, 0, 0);
    plan(d_load, 0, 3, 0);
    play_n(7);
    dmem_ack = 1'b0; if_ack = 1'b0;
    #1;
    chk("mid_mem_req_before", 32'(dmem_req), 32'(sq[0].dmem_req));
    chk("mid_mem_instret_before", instret, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_mem_req_dropped", 32'(dmem_req), 32'd0);
    chk("mid_mem_instret_clr", instret, 32'd0);
    chk("mid_mem_no_retire", 32'(retire), 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    // Counter wrap from all-ones to zero on one retire.
    dut.instret_q = 32'hFFFF_FFFF;
    m_instret     = 32'hFFFF_FFFF;
    plan(d_add, 0, 0, 0);
    play_all();
    chk("instret_wrap", instret, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
